// File: rtl/display_hex_byte.sv
// display_hex_byte: shows one byte as two hex digits on a 3-digit multiplexed
// 7-segment display. Digits are scanned 0 -> 1 -> 2, each lit for DIV clocks.
// All outputs are registered and active-low.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset (display dark while low)
//   hex_byte        value to show; [7:4] high digit, [3:0] low digit
//   segments        {dp,g,f,e,d,c,b,a}, 0 = lit
//   segments_enable digit enables, 0 = on; [0] low nibble, [1] high nibble, [2] suffix
//
// Build option: define HEX_SUFFIX_EN to show a lowercase 'h' on digit 2;
// otherwise digit 2 is blank but still takes its scan slot.
module display_hex_byte #(
  parameter int unsigned DIV   = 16384,
  parameter int unsigned DIV_W = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hex_byte,
  output logic [7:0] segments,
  output logic [2:0] segments_enable
);

  localparam logic [DIV_W-1:0] CntLast = DIV_W'(DIV - 1);

`ifdef HEX_SUFFIX_EN
  localparam logic [7:0] SuffixSeg = 8'h8B;  // 'h': c,e,f,g lit
`else
  localparam logic [7:0] SuffixSeg = 8'hFF;
`endif

  typedef enum logic [1:0] {StDig0, StDig1, StDig2} digit_e;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  digit_e           digit_q, digit_d;
  logic [7:0]       byte_q, byte_d;
  logic             run_q;
  logic [7:0]       seg_q, seg_d;
  logic [2:0]       en_q, en_d;
  logic             load;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    unique case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    digit_d = digit_q;
    byte_d  = byte_q;
    seg_d   = seg_q;
    en_d    = en_q;
    load    = 1'b0;

    if (!run_q) begin
      // First edge after reset: start the scan on digit 0 with a fresh sample.
      cnt_d   = '0;
      digit_d = StDig0;
      byte_d  = hex_byte;
      load    = 1'b1;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
      load  = 1'b1;
      unique case (digit_q)
        StDig0:  digit_d = StDig1;
        StDig1:  digit_d = StDig2;
        default: begin
          digit_d = StDig0;
          // Sample only when entering digit 0 so both digits of a scan agree.
          byte_d  = hex_byte;
        end
      endcase
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    if (load) begin
      unique case (digit_d)
        StDig0: begin
          seg_d = seg_decode(byte_d[3:0]);
          en_d  = 3'b110;
        end
        StDig1: begin
          seg_d = seg_decode(byte_d[7:4]);
          en_d  = 3'b101;
        end
        default: begin
          seg_d = SuffixSeg;
          en_d  = 3'b011;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      digit_q <= StDig0;
      byte_q  <= 8'h00;
      run_q   <= 1'b0;
      seg_q   <= 8'hFF;
      en_q    <= 3'b111;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      byte_q  <= byte_d;
      run_q   <= 1'b1;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  assign segments        = seg_q;
  assign segments_enable = en_q;

endmodule

// File: tb/tb_display_hex_byte.sv
// Scoreboard bench for display_hex_byte: the driver pushes one expected
// {enable, segments} entry per lit cycle; the monitor pops one entry on every
// falling edge where a digit is enabled and compares.
module tb_display_hex_byte;

  parameter int unsigned DIV = 4;
  localparam int unsigned DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int unsigned SCAN = 3 * DIV;

`ifdef HEX_SUFFIX_EN
  localparam logic [7:0] ExpSuffix = 8'h8B;
`else
  localparam logic [7:0] ExpSuffix = 8'hFF;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] hex_byte;
  logic [7:0] segments;
  logic [2:0] segments_enable;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];

  display_hex_byte #(
    .DIV  (DIV),
    .DIV_W(DIV_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hex_byte       (hex_byte),
    .segments       (segments),
    .segments_enable(segments_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_seg(input logic [3:0] nib);
    logic [7:0] tab [16];
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tab[nib];
  endfunction

  task automatic push_scan(input logic [7:0] v);
    for (int i = 0; i < int'(DIV); i++) exp_q.push_back({3'b110, ref_seg(v[3:0])});
    for (int i = 0; i < int'(DIV); i++) exp_q.push_back({3'b101, ref_seg(v[7:4])});
    for (int i = 0; i < int'(DIV); i++) exp_q.push_back({3'b011, ExpSuffix});
  endtask

  task automatic check_dark(input string name);
    checks++;
    if (segments !== 8'hFF || segments_enable !== 3'b111) begin
      errors++;
      $display("FAIL %s: got en=%b seg=%h, want en=111 seg=FF", name, segments_enable, segments);
    end
  endtask

  // Monitor: every lit cycle must match the next expected entry.
  always @(negedge clk) begin
    logic [10:0] e;
    int zeros;
    if (rst_n === 1'b1 && segments_enable !== 3'b111) begin
      zeros = 0;
      for (int b = 0; b < 3; b++) if (segments_enable[b] === 1'b0) zeros++;
      checks++;
      if (zeros != 1) begin
        errors++;
        $display("FAIL onehot: got en=%b, want exactly one low bit", segments_enable);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got en=%b seg=%h, want no lit digit",
                 segments_enable, segments);
      end else begin
        e = exp_q.pop_front();
        if ({segments_enable, segments} !== e) begin
          errors++;
          $display("FAIL scan: got en=%b seg=%h, want en=%b seg=%h",
                   segments_enable, segments, e[10:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    hex_byte = 8'h3C;

    // Reset held for 5 clocks: display stays dark.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_dark("reset_hold");
    end

    // 3C: two full scans of (110,C6)(101,B0)(011,suffix).
    rst_n = 1'b1;
    push_scan(8'h3C);
    push_scan(8'h3C);
    repeat (2 * SCAN) @(negedge clk);

    // Sweep every byte value, one scan each.
    for (int v = 0; v < 256; v++) begin
      hex_byte = 8'(v);
      push_scan(8'(v));
      repeat (SCAN) @(negedge clk);
    end

    // Tearing: byte changes while digit 0 is lit; digit 1 keeps the old value.
    hex_byte = 8'h12;
    push_scan(8'h12);
    repeat (2) @(negedge clk);
    hex_byte = 8'hAB;
    repeat (SCAN - 2) @(negedge clk);
    push_scan(8'hAB);
    repeat (SCAN) @(negedge clk);

    // Reset mid-scan: outputs go dark before any clock edge.
    hex_byte = 8'h55;
    push_scan(8'h55);
    repeat (DIV + 1) @(negedge clk);
    #2;
    checks++;
    if (segments_enable === 3'b111) begin
      errors++;
      $display("FAIL midscan_lit: got en=%b, want a digit enabled", segments_enable);
    end
    rst_n = 1'b0;
    #1;
    check_dark("midscan_async");
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_dark("midscan_hold");
    end

    // Restart with a fresh sample.
    hex_byte = 8'hF0;
    rst_n    = 1'b1;
    push_scan(8'hF0);
    repeat (SCAN) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_dark("final_reset");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
